// File: rtl/qspi_ram_pkg.sv
// Shared opcodes and FSM state type for the oversampled QSPI RAM peripheral.
package qspi_ram_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_QREAD     = 8'h6B;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_QWRITE    = 8'h32;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StRead,
    StWrite,
    StIgnore
  } state_e;

  function automatic logic op_known(logic [7:0] op);
    return op inside {OP_READ, OP_FAST_READ, OP_QREAD, OP_WRITE, OP_QWRITE};
  endfunction

endpackage

// File: rtl/qspi_ram_oversampled_if.sv
// SPI pad bundle plus debug read port of the oversampled QSPI RAM.
interface qspi_ram_oversampled_if #(
  parameter int unsigned ADDR_BITS = 3
);
  logic                 spi_clk;
  logic                 spi_select;
  logic [3:0]           spi_d_in;
  logic [3:0]           spi_d_out;
  logic [3:0]           spi_d_oe;
  logic [ADDR_BITS-1:0] dbg_addr;
  logic [7:0]           dbg_data;
  logic                 busy;

  modport master (
    output spi_clk, spi_select, spi_d_in, dbg_addr,
    input  spi_d_out, spi_d_oe, dbg_data, busy
  );

  modport slave (
    input  spi_clk, spi_select, spi_d_in, dbg_addr,
    output spi_d_out, spi_d_oe, dbg_data, busy
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for SCK, CS and D0..D3 with SCK edge and CS fall pulses.
module spi_pin_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_select,
  input  logic [3:0] spi_d_in,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       sel,
  output logic       sel_fall,
  output logic [3:0] d
);
  logic [5:0] s1_q, s2_q;
  logic       sck3_q, sel3_q;

  // CS chain resets low so a select held low across reset never looks like a new fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      sck3_q <= 1'b0;
      sel3_q <= 1'b0;
    end else begin
      s1_q   <= {spi_clk, spi_select, spi_d_in};
      s2_q   <= s1_q;
      sck3_q <= s2_q[5];
      sel3_q <= s2_q[4];
    end
  end

  assign sck_rise = s2_q[5] & ~sck3_q;
  assign sck_fall = ~s2_q[5] & sck3_q;
  assign sel      = s2_q[4];
  assign sel_fall = ~s2_q[4] & sel3_q;
  assign d        = s2_q[3:0];
endmodule

// File: rtl/qspi_ram_oversampled.sv
// SPI/QSPI RAM running entirely on clk; SPI pads are oversampled, debug port reads the same RAM.
module qspi_ram_oversampled
  import qspi_ram_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 3,
  parameter int unsigned ADDR_BYTES   = 3,
  parameter int unsigned DUMMY_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  qspi_ram_oversampled_if.slave bus
);
  localparam int unsigned Depth     = 2 ** ADDR_BITS;
  localparam logic [4:0]  AddrLast  = 5'(8 * ADDR_BYTES - 1);
  localparam logic [4:0]  DummyLast = 5'(DUMMY_CYCLES - 1);

  logic       sck_rise, sck_fall, sel, sel_fall;
  logic [3:0] d;

  spi_pin_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (bus.spi_clk),
    .spi_select(bus.spi_select),
    .spi_d_in  (bus.spi_d_in),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .sel       (sel),
    .sel_fall  (sel_fall),
    .d         (d)
  );

  logic [7:0]           mem [Depth];
  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d, step;
  logic [7:0]           sr_q, sr_d, op_q, op_d, tx_q, tx_d, cur, rd_byte;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 quad_q, quad_d, we;
  logic [3:0]           d_out_q, d_out_d, oe_q, oe_d;
  logic [7:0]           dbg_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    op_d    = op_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    quad_d  = quad_q;
    d_out_d = d_out_q;
    oe_d    = oe_q;
    we      = 1'b0;
    rd_byte = mem[addr_q];
    cur     = tx_q;
    step    = quad_q ? 3'd4 : 3'd1;
    if (sel) begin
      // deselect wins over any SCK edge seen in the same clk
      state_d = StIdle;
      oe_d    = 4'b0000;
      d_out_d = 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
            quad_d  = 1'b0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            sr_d  = {sr_q[6:0], d[0]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              op_d    = sr_d;
              cnt_d   = '0;
              state_d = op_known(sr_d) ? StAddr : StIgnore;
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            addr_d = ADDR_BITS'({addr_q, d[0]});
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == AddrLast) begin
              cnt_d = '0;
              bit_d = '0;
              case (op_q)
                OP_READ:      state_d = StRead;
                OP_FAST_READ: state_d = StDummy;
                OP_QREAD:     begin state_d = StDummy; quad_d = 1'b1; end
                OP_QWRITE:    begin state_d = StWrite; quad_d = 1'b1; end
                default:      state_d = StWrite;
              endcase
            end
          end
        end
        StDummy: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DummyLast) begin
              cnt_d   = '0;
              state_d = StRead;
            end
          end
        end
        StRead: begin
          if (sck_fall) begin
            if (bit_q == 3'd0) begin
              cur    = rd_byte;
              addr_d = addr_q + 1'b1;
            end
            oe_d    = quad_q ? 4'b1111 : 4'b0010;
            d_out_d = quad_q ? cur[7:4] : {2'b00, cur[7], 1'b0};
            tx_d    = quad_q ? {cur[3:0], 4'h0} : {cur[6:0], 1'b0};
            bit_d   = bit_q + step;
          end
        end
        StWrite: begin
          if (sck_rise) begin
            sr_d  = quad_q ? {sr_q[3:0], d} : {sr_q[6:0], d[0]};
            bit_d = bit_q + step;
            if (bit_d == 3'd0) begin
              we     = 1'b1;
              addr_d = addr_q + 1'b1;
            end
          end
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      quad_q  <= 1'b0;
      d_out_q <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      quad_q  <= quad_d;
      d_out_q <= d_out_d;
      oe_q    <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr_q] <= sr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_q <= '0;
    else        dbg_q <= mem[bus.dbg_addr];
  end

  assign bus.spi_d_out = d_out_q;
  assign bus.spi_d_oe  = oe_q;
  assign bus.dbg_data  = dbg_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_qspi_ram_oversampled.sv
// Directed bench: two RAMs (2 and 8 dummy cycles) share one set of SPI pads.
module tb_qspi_ram_oversampled;
  logic       clk = 1'b0;
  logic       rst_n, sck, sel;
  logic [3:0] d_in;
  logic [2:0] dbg_a;
  logic [3:0] cap_out, cap_oe, cap_out8, cap_oe8;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  qspi_ram_oversampled_if #(.ADDR_BITS(3)) bus ();
  qspi_ram_oversampled_if #(.ADDR_BITS(3)) bus8 ();

  assign bus.spi_clk     = sck;
  assign bus.spi_select  = sel;
  assign bus.spi_d_in    = d_in;
  assign bus.dbg_addr    = dbg_a;
  assign bus8.spi_clk    = sck;
  assign bus8.spi_select = sel;
  assign bus8.spi_d_in   = d_in;
  assign bus8.dbg_addr   = dbg_a;

  qspi_ram_oversampled #(.ADDR_BITS(3), .ADDR_BYTES(3), .DUMMY_CYCLES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  qspi_ram_oversampled #(.ADDR_BITS(3), .ADDR_BYTES(3), .DUMMY_CYCLES(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SCK period of 10 clk; outputs are captured just before the rise.
  task automatic sck_cycle(input logic [3:0] din);
    d_in = din;
    repeat (5) @(negedge clk);
    cap_out  = bus.spi_d_out;
    cap_oe   = bus.spi_d_oe;
    cap_out8 = bus8.spi_d_out;
    cap_oe8  = bus8.spi_d_oe;
    sck = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic read_byte(output logic [7:0] b, output logic oe_ok);
    oe_ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      sck_cycle(4'h0);
      b[i] = cap_out[1];
      if (cap_oe !== 4'b0010) oe_ok = 1'b0;
    end
  endtask

  task automatic cs_begin();
    sel = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (5) @(negedge clk);
    sel = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic dbg_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_a = a;
    repeat (2) @(negedge clk);
    check(tag, bus.dbg_data, exp);
  endtask

  logic [7:0]  rb;
  logic [15:0] nib;
  logic        ok;

  initial begin
    rst_n = 1'b0;
    sck   = 1'b0;
    sel   = 1'b1;
    d_in  = 4'h0;
    dbg_a = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_oe", bus.spi_d_oe, 4'b0000);
    check("reset_out", bus.spi_d_out, 4'b0000);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_dbg", bus.dbg_data, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single-bit write A5h to address 5
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000005);
    check("busy_write", bus.busy, 1'b1);
    send_byte(8'hA5);
    cs_end();
    check("busy_idle", bus.busy, 1'b0);
    dbg_check("wr_a5", 3'd5, 8'hA5);

    // quad write at 6: nibbles 1..6 land in 6, 7 and wrap to 0
    cs_begin();
    send_byte(8'h32);
    send_addr(24'h000006);
    for (int i = 1; i <= 6; i++) sck_cycle(4'(i));
    cs_end();
    dbg_check("qwr_6", 3'd6, 8'h12);
    dbg_check("qwr_7", 3'd7, 8'h34);
    dbg_check("qwr_wrap_0", 3'd0, 8'h56);

    // quad read at 6 with two dummies
    cs_begin();
    send_byte(8'h6B);
    send_addr(24'h000006);
    sck_cycle(4'h0);
    sck_cycle(4'h0);
    check("qrd_oe_dummy", cap_oe, 4'b0000);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sck_cycle(4'h0);
      nib = {nib[11:0], cap_out};
      if (cap_oe !== 4'b1111) ok = 1'b0;
    end
    check("qrd_nibbles", nib, 16'h1234);
    check("qrd_oe", ok, 1'b1);
    cs_end();
    check("qrd_oe_deselect", bus.spi_d_oe, 4'b0000);

    // single read at 7 with high byte FFh: wraps from 7 to 0
    cs_begin();
    send_byte(8'h03);
    send_addr(24'hFFFF07);
    read_byte(rb, ok);
    check("rd_7", rb, 8'h34);
    check("rd_oe", ok, 1'b1);
    read_byte(rb, ok);
    check("rd_wrap_0", rb, 8'h56);
    cs_end();

    // seed address 2, then a 5-bit partial write must be dropped
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000002);
    send_byte(8'hC3);
    cs_end();
    dbg_check("wr_c3", 3'd2, 8'hC3);
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000002);
    for (int i = 0; i < 5; i++) sck_cycle(4'h1);
    cs_end();
    dbg_check("partial_dropped", 3'd2, 8'hC3);

    // unknown opcode: ignored until deselect
    cs_begin();
    send_byte(8'h9F);
    for (int i = 0; i < 4; i++) sck_cycle(4'hF);
    check("ign_oe", cap_oe, 4'b0000);
    check("ign_busy", bus.busy, 1'b1);
    cs_end();
    check("ign_exit", bus.busy, 1'b0);

    // fast read on the 8-dummy instance: first bit on the 9th fall after the address
    cs_begin();
    send_byte(8'h0B);
    send_addr(24'h000005);
    for (int i = 0; i < 8; i++) sck_cycle(4'h0);
    check("fr8_oe_fall8", cap_oe8, 4'b0000);
    sck_cycle(4'h0);
    check("fr8_oe_fall9", cap_oe8, 4'b0010);
    check("fr8_bit7", cap_out8, 4'b0010);
    sck_cycle(4'h0);
    check("fr8_bit6", cap_out8[1], 1'b0);
    sck_cycle(4'h0);
    check("fr8_bit5", cap_out8[1], 1'b1);
    cs_end();

    // CS rise together with the SCK rise completing a byte: no write
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000002);
    for (int i = 0; i < 7; i++) sck_cycle(4'h0);
    d_in = 4'h0;
    repeat (5) @(negedge clk);
    sck = 1'b1;
    sel = 1'b1;
    repeat (10) @(negedge clk);
    sck = 1'b0;
    repeat (5) @(negedge clk);
    check("cs_race_busy", bus.busy, 1'b0);
    dbg_check("cs_race_nowrite", 3'd2, 8'hC3);

    // reset during a quad read clears outputs and does not resume
    cs_begin();
    send_byte(8'h6B);
    send_addr(24'h000006);
    for (int i = 0; i < 3; i++) sck_cycle(4'h0);
    check("rst_pre_oe", cap_oe, 4'b1111);
    rst_n = 1'b0;
    #1;
    check("rst_async_oe", bus.spi_d_oe, 4'b0000);
    check("rst_async_out", bus.spi_d_out, 4'b0000);
    check("rst_async_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) sck_cycle(4'h0);
    check("rst_no_resume_busy", bus.busy, 1'b0);
    check("rst_no_resume_oe", cap_oe, 4'b0000);
    cs_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
